// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin arbiter sharing one register file write port, sinking x0 writes
module regfile_wb_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_rd,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic                             wr_en,
  output logic [ADDR_WIDTH-1:0]            rd,
  output logic [DATA_WIDTH-1:0]            rd_value,
  output logic [2:0]                       grant_id,
  output logic                             wb_stall,
  output logic [15:0]                      contention_cnt
);
  logic [NUM_REQ-1:0]    live, x0, ready;
  logic                  gnt;
  logic [2:0]            g;
  logic [ADDR_WIDTH-1:0] sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;
  int                    n_live;
  logic [2:0]            ptr_q, ptr_d, grant_id_q, grant_id_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [DATA_WIDTH-1:0] rd_value_q, rd_value_d;
  logic [15:0]           cnt_q, cnt_d;
  always_comb begin
    n_live = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      live[i] = req_valid[i] && (|req_rd[i*ADDR_WIDTH +: ADDR_WIDTH]);
      x0[i]   = req_valid[i] && !(|req_rd[i*ADDR_WIDTH +: ADDR_WIDTH]);
      n_live  = n_live + int'(live[i]);
    end
  end
  always_comb begin
    gnt      = 1'b0;
    g        = '0;
    sel_rd   = '0;
    sel_data = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      for (int i = 0; i < NUM_REQ; i++)
        if (live[i] && i == (int'(ptr_q) + k) % NUM_REQ) begin
          gnt      = 1'b1;
          g        = 3'(i);
          sel_rd   = req_rd[i*ADDR_WIDTH +: ADDR_WIDTH];
          sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
  end
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      ready[i] = rst_n && (x0[i] || (gnt && g == 3'(i)));
  end
  always_comb begin
    ptr_d      = gnt ? 3'((int'(g) + 1) % NUM_REQ) : ptr_q;
    wr_en_d    = gnt;
    rd_d       = gnt ? sel_rd : '0;
    rd_value_d = gnt ? sel_data : '0;
    grant_id_d = gnt ? g : grant_id_q;
    cnt_d      = (n_live >= 2 && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      wr_en_q    <= 1'b0;
      rd_q       <= '0;
      rd_value_q <= '0;
      grant_id_q <= '0;
      cnt_q      <= '0;
    end else begin
      ptr_q      <= ptr_d;
      wr_en_q    <= wr_en_d;
      rd_q       <= rd_d;
      rd_value_q <= rd_value_d;
      grant_id_q <= grant_id_d;
      cnt_q      <= cnt_d;
    end
  end
  assign req_ready      = ready;
  assign wb_stall       = rst_n && |(req_valid & ~ready);
  assign wr_en          = wr_en_q;
  assign rd             = rd_q;
  assign rd_value       = rd_value_q;
  assign grant_id       = grant_id_q;
  assign contention_cnt = cnt_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed vectors plus a cycle-level reference model of the write-port arbiter
module tb_regfile_wb_arbiter;
  localparam int N = 3, AW = 5, DW = 32;
  logic            clk = 1'b0, rst_n = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_rd = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            wr_en, wb_stall;
  logic [AW-1:0]   rd;
  logic [DW-1:0]   rd_value;
  logic [2:0]      grant_id;
  logic [15:0]     contention_cnt;
  int              n_chk = 0, n_fail = 0;
  int              m_ptr;
  logic            m_wr;
  logic [AW-1:0]   m_rd;
  logic [DW-1:0]   m_val;
  logic [2:0]      m_gid;
  logic [15:0]     m_cnt;
  regfile_wb_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data),
    .req_ready(req_ready), .wr_en(wr_en), .rd(rd), .rd_value(rd_value), .grant_id(grant_id),
    .wb_stall(wb_stall), .contention_cnt(contention_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic set_req(input int i, input logic [AW-1:0] r, input logic [DW-1:0] d);
    req_rd[i*AW +: AW]   = r;
    req_data[i*DW +: DW] = d;
  endtask
  function automatic logic is_live(input int i);
    return req_valid[i] && req_rd[i*AW +: AW] != 0;
  endfunction
  function automatic int winner(input int p);
    for (int k = 0; k < N; k++)
      if (is_live((p + k) % N)) return (p + k) % N;
    return -1;
  endfunction
  function automatic int n_live();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(is_live(i));
    return c;
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr <= 0; m_wr <= 1'b0; m_rd <= '0; m_val <= '0; m_gid <= '0; m_cnt <= '0;
    end else if (winner(m_ptr) >= 0) begin
      m_ptr <= (winner(m_ptr) + 1) % N;
      m_wr  <= 1'b1;
      m_rd  <= req_rd[winner(m_ptr)*AW +: AW];
      m_val <= req_data[winner(m_ptr)*DW +: DW];
      m_gid <= 3'(winner(m_ptr));
      m_cnt <= (n_live() >= 2 && m_cnt != 16'hFFFF) ? m_cnt + 16'd1 : m_cnt;
    end else begin
      m_wr  <= 1'b0;
      m_rd  <= '0;
      m_val <= '0;
      m_cnt <= (n_live() >= 2 && m_cnt != 16'hFFFF) ? m_cnt + 16'd1 : m_cnt;
    end
  end
  always @(negedge clk) begin
    if (rst_n) begin
      logic [N-1:0] er;
      for (int i = 0; i < N; i++)
        er[i] = req_valid[i] && (req_rd[i*AW +: AW] == 0 || i == winner(m_ptr));
      chk("m_ready", 32'(req_ready), 32'(er));
      chk("m_stall", 32'(wb_stall), 32'(|(req_valid & ~er)));
      chk("m_wr_en", 32'(wr_en), 32'(m_wr));
      chk("m_rd", 32'(rd), 32'(m_rd));
      chk("m_rd_value", rd_value, m_val);
      chk("m_grant_id", 32'(grant_id), 32'(m_gid));
      chk("m_cnt", 32'(contention_cnt), 32'(m_cnt));
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #1 rst_n = 1'b0;
    req_valid = 3'b111;
    set_req(0, 5'd1, 32'h1); set_req(1, 5'd2, 32'h2); set_req(2, 5'd3, 32'h3);
    #2;
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_rd", 32'(rd), 0);
    chk("rst_rd_value", rd_value, 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_cnt", 32'(contention_cnt), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_stall", 32'(wb_stall), 0);
    req_valid = '0;
    #9 rst_n = 1'b1;
    step();
    req_valid = 3'b010; set_req(1, 5'd5, 32'hDEADBEEF);
    #1 chk("single_ready", 32'(req_ready), 32'b010);
    step();
    req_valid = '0;
    chk("single_wr_en", 32'(wr_en), 1);
    chk("single_rd", 32'(rd), 5);
    chk("single_value", rd_value, 32'hDEADBEEF);
    chk("single_gid", 32'(grant_id), 1);
    chk("model_gid_pin", 32'(m_gid), 1);
    step();
    chk("single_idle", 32'(wr_en), 0);
    @(posedge clk); #1 rst_n = 1'b0;
    req_valid = 3'b111;
    set_req(0, 5'd1, 32'h11); set_req(1, 5'd2, 32'h22); set_req(2, 5'd3, 32'h33);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rr_gid", 32'(grant_id), 32'(k % 3));
      chk("rr_wr_en", 32'(wr_en), 1);
      chk("rr_cnt", 32'(contention_cnt), 32'(k + 1));
    end
    req_valid = 3'b101; set_req(0, 5'd0, 32'h99); set_req(2, 5'd7, 32'h1234);
    #1 chk("x0_ready", 32'(req_ready), 32'b101);
    step();
    req_valid = 3'b001; set_req(0, 5'd4, 32'hA);
    chk("x0_rd", 32'(rd), 7);
    chk("x0_value", rd_value, 32'h1234);
    chk("x0_cnt", 32'(contention_cnt), 6);
    step();
    chk("pre_stall_rd", 32'(rd), 4);
    req_valid = 3'b011; set_req(0, 5'd8, 32'hB); set_req(1, 5'd9, 32'hC);
    #1 chk("stall_ready", 32'(req_ready), 32'b010);
    chk("stall_on", 32'(wb_stall), 1);
    step();
    req_valid = 3'b001;
    chk("stall_gid", 32'(grant_id), 1);
    chk("stall_rd", 32'(rd), 9);
    chk("stall_cnt", 32'(contention_cnt), 7);
    #1 chk("stall_off", 32'(wb_stall), 0);
    chk("stall_ready2", 32'(req_ready), 32'b001);
    step();
    chk("stall_gid2", 32'(grant_id), 0);
    chk("stall_value2", rd_value, 32'hB);
    req_valid = 3'b111;
    set_req(0, 5'd1, 32'h11); set_req(1, 5'd2, 32'h22); set_req(2, 5'd3, 32'h33);
    step();
    chk("mid_gid", 32'(grant_id), 1);
    chk("mid_wr_en", 32'(wr_en), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_wr_en", 32'(wr_en), 0);
    chk("arst_rd", 32'(rd), 0);
    chk("arst_value", rd_value, 0);
    chk("arst_cnt", 32'(contention_cnt), 0);
    #1 rst_n = 1'b1;
    step();
    chk("arst_first_gid", 32'(grant_id), 0);
    chk("arst_first_wr", 32'(wr_en), 1);
    req_valid = 3'b011;
    repeat (70000) @(posedge clk);
    #1 chk("sat_cnt", 32'(contention_cnt), 32'hFFFF);
    repeat (3) step();
    chk("sat_hold", 32'(contention_cnt), 32'hFFFF);
    req_valid = '0;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the register file's single write port between several writeback sources, e.g. ALU, load unit and mul/div. Each source presents a valid/ready request. The block grants one non-x0 request per cycle in round-robin order and drives the register file write port (`wr_en`, `rd`, `rd_value`) from a registered output stage. Writes to x0 are absorbed without using the port. It sits between the execute/memory writeback muxes and the register file.

## Interface
- `NUM_REQ`, 3: number of writeback requesters (2..8).
- `DATA_WIDTH`, 32: write data width.
- `ADDR_WIDTH`, 5: register index width.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NUM_REQ  per-requester write request.
- `req_rd`  in  NUM_REQ*ADDR_WIDTH  destination index; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_data`  in  NUM_REQ*DATA_WIDTH  write data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready`  out  NUM_REQ  request accepted this cycle (combinational).
- `wr_en`  out  1  register file write enable (registered).
- `rd`  out  ADDR_WIDTH  register file write index (registered).
- `rd_value`  out  DATA_WIDTH  register file write data (registered).
- `grant_id`  out  3  index of the requester whose write is currently on the port (registered).
- `wb_stall`  out  1  at least one valid request is not ready this cycle (combinational).
- `contention_cnt`  out  16  saturating count of cycles with two or more valid non-x0 requests.

## Operation
- **Request classes**
  - x0 request: `req_valid[i]` high and `req_rd` slice equal to 0. Sunk immediately: `req_ready[i]=1` in the same cycle, no port use. All x0 requests are sunk in parallel.
  - Live request: `req_valid[i]` high and `req_rd` non-zero. Competes for the single grant.
- **Arbitration**
  - Winner g is the first live requester found scanning `ptr, ptr+1, …` modulo NUM_REQ.
  - `req_ready[g]=1`. Every other live requester sees ready low.
- **Pointer update**
  - On a grant: `ptr <= (g+1) mod NUM_REQ`.
  - No grant: `ptr` holds.
  - Worst-case wait for a continuously valid live requester is NUM_REQ-1 cycles.
- **Output stage**
  - On a grant, at the next edge: `wr_en<=1`, `rd<=req_rd[g]`, `rd_value<=req_data[g]`, `grant_id<=g`.
  - No grant: `wr_en<=0`, `rd<=0`, `rd_value<=0`, `grant_id` holds.
  - The output stage never stalls; the register file accepts a write every cycle.
- **Requester obligations**
  - Once valid is asserted, hold valid, rd and data stable until ready is seen.
  - Never retract an unserved request.
  - The arbiter does not check this. A violation produces undefined written data.
- **Ordering**
  - Two requesters targeting the same rd in the same cycle are written in grant order; the later grant wins the final value.
  - Upstream hazard logic prevents this case. The arbiter does not merge writes.
- **`wb_stall`** = OR over i of (`req_valid[i]` & ~`req_ready[i]`).
- **`contention_cnt`**
  - Increments by 1 each cycle with two or more live requests.
  - Saturates at 16'hFFFF and never wraps.
  - Cleared only by reset.
- **Out-of-range inputs:** bits of `req_valid` above NUM_REQ do not exist. `grant_id` is zero-extended to 3 bits.

## Timing
- Reset (`rst_n` low, async):
  - `wr_en=0`, `rd=0`, `rd_value=0`, `grant_id=0`, `ptr=0`, `contention_cnt=0`.
  - `req_ready` and `wb_stall` are forced to 0 while `rst_n` is low.
- Reset asserted mid-operation: a grant in flight is dropped and `wr_en` clears immediately. The requester is not re-served unless it re-presents after reset release.
- First grant is possible in the first cycle with `rst_n` high.
- Latency:
  - Request accepted at edge N.
  - Write port is driven during cycle N→N+1.
  - Register file captures the write at edge N+1.
- Throughput: one register file write per cycle. Back-to-back grants keep `wr_en` high continuously.
- `req_ready` depends combinationally on `req_valid`/`req_rd` of all requesters and on `ptr`. `wr_en`, `rd`, `rd_value` and `grant_id` depend only on flops.

## Test plan
- **Single requester:** after reset, req 1 valid, rd=5, data=0xDEADBEEF for one cycle.
  - Expect `req_ready[1]=1` that cycle.
  - Next cycle: `wr_en=1`, `rd=5`, `rd_value=0xDEADBEEF`, `grant_id=1`.
  - Following cycle: `wr_en=0`.
- **Round-robin:** all three valid continuously with rd=1,2,3 from reset.
  - Grants in order 0,1,2,0,1,2.
  - `wr_en` stays high.
  - `contention_cnt` increments every cycle.
- **x0 sink:** req 0 rd=0 and req 2 rd=7 valid in the same cycle.
  - Both ready that cycle.
  - Only rd=7 is written.
  - `contention_cnt` unchanged.
- **Stall:** req 0 and req 1 live with ptr=1.
  - Req 1 granted.
  - `wb_stall=1` for exactly that cycle.
  - Req 0 granted next cycle.
- **Async reset mid-stream:** pulse `rst_n` low between edges while `wr_en=1`.
  - `wr_en`, `rd` and `rd_value` go to 0 immediately.
  - `ptr` returns to 0.
  - Requester 0 is granted first after release.
- **Saturation:** hold two live requests for 70000 cycles.
  - `contention_cnt` reaches 0xFFFF and stays there.
